uart_cmd_sequencer: RTL and testbench

UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

---
 rtl/uart_cmd_sequencer_pkg.sv | 28 ++
 rtl/uart_cmd_sequencer_if.sv | 23 ++
 rtl/uart_byte_timeout.sv | 36 +++
 rtl/uart_cmd_sequencer_fsm.sv | 204 ++++++++++++++++++++
 rtl/uart_cmd_sequencer.sv | 46 ++++
 tb/tb_uart_cmd_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/uart_cmd_sequencer_pkg.sv
// Shared types and constants for the UART command sequencer and its bench.
package uart_cmd_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LEN   = 3'd2,
        ST_DATA  = 3'd3,
        ST_CHK   = 3'd4,
        ST_WRITE = 3'd5,
        ST_DONE  = 3'd6
    } seq_state_e;

    typedef enum logic [1:0] {
        ERR_TIMEOUT = 2'd0,
        ERR_BAD_LEN = 2'd1,
        ERR_BAD_CHK = 2'd2,
        ERR_OVERRUN = 2'd3
    } err_code_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         MAX_LEN_LIMIT = 15;

    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// Byte-in / register-write-out bundle between the host side and the sequencer.
interface uart_cmd_sequencer_if;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       frame_done;
    logic       err;
    logic [1:0] err_code;
    logic       busy;

    modport master (
        output rx_dv, rx_byte, wr_ack,
        input  wr_en, wr_addr, wr_data, frame_done, err, err_code, busy
    );

    modport slave (
        input  rx_dv, rx_byte, wr_ack,
        output wr_en, wr_addr, wr_data, frame_done, err, err_code, busy
    );
endinterface

// File: rtl/uart_byte_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags the limit.
module uart_byte_timeout #(
    parameter int TIMEOUT_CLKS = 20000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int             CW    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CLKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !enable_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Not gated by clear_i so the FSM's next-state logic can feed clear_i without a loop.
    assign expired_o = enable_i && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_cmd_sequencer_fsm.sv
// Frame parser and register-write issuer: SYNC, ADDR, LEN, payload, XOR checksum.
module uart_cmd_sequencer_fsm
    import uart_cmd_sequencer_pkg::*;
#(
    parameter int         MAX_LEN      = 4,
    parameter int         TIMEOUT_CLKS = 20000,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input logic                 clk_i,
    input logic                 rst_i,
    uart_cmd_sequencer_if.slave bus
);
    localparam int IW = $clog2(MAX_LEN + 1);

    seq_state_e    state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    chk_q, chk_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [IW-1:0] len_q, len_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          wr_en_q, wr_en_d;
    logic [7:0]    buf_q [MAX_LEN];

    logic          buf_we;
    logic          err;
    err_code_e     err_code;
    logic          done;
    logic          last_idx;
    logic [7:0]    rd_data;
    logic          tmo_en, tmo_clr, tmo_exp;

    assign last_idx = (idx_q == len_q - IW'(1));

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_q == IW'(i)) rd_data = buf_q[i];
        end
    end

    assign tmo_en  = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                     (state_q == ST_DATA) || (state_q == ST_CHK);
    assign tmo_clr = bus.rx_dv || (state_d != state_q);

    uart_byte_timeout #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (tmo_clr),
        .enable_i  (tmo_en),
        .expired_o (tmo_exp)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        chk_d     = chk_q;
        len_d     = len_q;
        idx_d     = idx_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        buf_we    = 1'b0;
        err       = 1'b0;
        err_code  = ERR_TIMEOUT;
        done      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.rx_dv && bus.rx_byte == SYNC_BYTE) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (bus.rx_dv) begin
                    addr_d  = bus.rx_byte;
                    chk_d   = bus.rx_byte;
                    state_d = ST_LEN;
                end else if (tmo_exp) begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_LEN: begin
                if (bus.rx_dv) begin
                    if (bus.rx_byte == 8'd0 || bus.rx_byte > 8'(MAX_LEN)) begin
                        err      = 1'b1;
                        err_code = ERR_BAD_LEN;
                        state_d  = ST_IDLE;
                    end else begin
                        len_d   = IW'(bus.rx_byte);
                        chk_d   = chk_fold(chk_q, bus.rx_byte);
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end
                end else if (tmo_exp) begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (bus.rx_dv) begin
                    buf_we = 1'b1;
                    chk_d  = chk_fold(chk_q, bus.rx_byte);
                    // Index restarts here so CHK already sees buffer[0] on the read mux.
                    if (last_idx) begin
                        idx_d   = '0;
                        state_d = ST_CHK;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else if (tmo_exp) begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (bus.rx_dv) begin
                    if (bus.rx_byte != chk_q) begin
                        err      = 1'b1;
                        err_code = ERR_BAD_CHK;
                        state_d  = ST_IDLE;
                    end else begin
                        idx_d     = '0;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = rd_data;
                        state_d   = ST_WRITE;
                    end
                end else if (tmo_exp) begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (bus.rx_dv) begin
                    err      = 1'b1;
                    err_code = ERR_OVERRUN;
                end
                // wr_en_q low is the mandatory gap cycle between writes of one frame.
                if (wr_en_q) begin
                    if (bus.wr_ack) begin
                        wr_en_d = 1'b0;
                        if (last_idx) state_d = ST_DONE;
                        else          idx_d   = idx_q + IW'(1);
                    end
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q + 8'(idx_q);
                    wr_data_d = rd_data;
                end
            end
            ST_DONE: begin
                if (bus.rx_dv) begin
                    err      = 1'b1;
                    err_code = ERR_OVERRUN;
                end else begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            chk_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            chk_q     <= chk_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= '0;
        end else if (buf_we) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (idx_q == IW'(i)) buf_q[i] <= bus.rx_byte;
            end
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.err        = err;
    assign bus.err_code   = err_code;
    assign bus.frame_done = done;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Top level: flat pin-compatible ports mapped onto the sequencer bus bundle.
module uart_cmd_sequencer
    import uart_cmd_sequencer_pkg::*;
#(
    parameter int         MAX_LEN      = 4,
    parameter int         TIMEOUT_CLKS = 20000,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Wr_En,
    output logic [7:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    input  logic       i_Wr_Ack,
    output logic       o_Frame_Done,
    output logic       o_Err,
    output logic [1:0] o_Err_Code,
    output logic       o_Busy
);
    uart_cmd_sequencer_if bus_if ();

    assign bus_if.rx_dv   = i_Rx_DV;
    assign bus_if.rx_byte = i_Rx_Byte;
    assign bus_if.wr_ack  = i_Wr_Ack;

    assign o_Wr_En      = bus_if.wr_en;
    assign o_Wr_Addr    = bus_if.wr_addr;
    assign o_Wr_Data    = bus_if.wr_data;
    assign o_Frame_Done = bus_if.frame_done;
    assign o_Err        = bus_if.err;
    assign o_Err_Code   = bus_if.err_code;
    assign o_Busy       = bus_if.busy;

    uart_cmd_sequencer_fsm #(
        .MAX_LEN      (MAX_LEN),
        .TIMEOUT_CLKS (TIMEOUT_CLKS),
        .SYNC_BYTE    (SYNC_BYTE)
    ) u_fsm (
        .clk_i (i_Clock),
        .rst_i (i_Reset),
        .bus   (bus_if.slave)
    );

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed frames with a queue scoreboard; a negedge monitor checks writes, errors and done pulses.
module tb_uart_cmd_sequencer;
    import uart_cmd_sequencer_pkg::*;

    localparam int MAX_LEN = 4;
    localparam int TMO     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_sequencer_if tb_if ();

    uart_cmd_sequencer #(
        .MAX_LEN      (MAX_LEN),
        .TIMEOUT_CLKS (TMO),
        .SYNC_BYTE    (SYNC_BYTE_DEF)
    ) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_Rx_DV      (tb_if.rx_dv),
        .i_Rx_Byte    (tb_if.rx_byte),
        .o_Wr_En      (tb_if.wr_en),
        .o_Wr_Addr    (tb_if.wr_addr),
        .o_Wr_Data    (tb_if.wr_data),
        .i_Wr_Ack     (tb_if.wr_ack),
        .o_Frame_Done (tb_if.frame_done),
        .o_Err        (tb_if.err),
        .o_Err_Code   (tb_if.err_code),
        .o_Busy       (tb_if.busy)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] wr_q [$];
    logic [1:0]  err_q [$];
    int          done_exp = 0;
    logic [7:0]  txq [$];

    int ack_delay = 0;
    bit stray_ack = 1'b0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        tb_if.rx_dv   = 1'b1;
        tb_if.rx_byte = b;
        @(posedge clk);
        #1;
        tb_if.rx_dv   = 1'b0;
        tb_if.rx_byte = 8'h00;
    endtask

    task automatic send_txq();
        foreach (txq[i]) send(txq[i]);
    endtask

    task automatic wait_quiet(input string name);
        int n = 0;
        while (tb_if.busy && n < 300) begin
            idle(1);
            n++;
        end
        chk(n < 300, name, n, 300);
        idle(2);
    endtask

    // Write acknowledger: acks after ack_delay cycles of wr_en; optional stray acks while wr_en is low.
    initial begin
        int wait_cnt = 0;
        tb_if.wr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tb_if.wr_ack = 1'b0;
            if (rst) begin
                wait_cnt = 0;
            end else if (tb_if.wr_en) begin
                if (wait_cnt >= ack_delay) begin
                    tb_if.wr_ack = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                tb_if.wr_ack = stray_ack;
            end
        end
    end

    // Monitor
    initial begin
        logic       prev_en = 1'b0;
        logic       prev_ack = 1'b0;
        logic [7:0] prev_addr = '0;
        logic [7:0] prev_data = '0;
        logic [15:0] exp_w;
        logic [1:0]  exp_e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tb_if.wr_en && prev_en && !prev_ack)
                    chk({tb_if.wr_addr, tb_if.wr_data} == {prev_addr, prev_data}, "wr_hold_stable",
                        {tb_if.wr_addr, tb_if.wr_data}, {prev_addr, prev_data});
                if (prev_en && prev_ack)
                    chk(!tb_if.wr_en, "wr_gap_after_ack", tb_if.wr_en, 0);
                if (tb_if.wr_en && tb_if.wr_ack) begin
                    chk(wr_q.size() != 0, "write_expected", {tb_if.wr_addr, tb_if.wr_data}, 0);
                    if (wr_q.size() != 0) begin
                        exp_w = wr_q.pop_front();
                        chk({tb_if.wr_addr, tb_if.wr_data} == exp_w, "write_addr_data",
                            {tb_if.wr_addr, tb_if.wr_data}, exp_w);
                    end
                end
                if (tb_if.err) begin
                    chk(!tb_if.frame_done, "err_done_overlap", tb_if.frame_done, 0);
                    chk(err_q.size() != 0, "err_expected", tb_if.err_code, 0);
                    if (err_q.size() != 0) begin
                        exp_e = err_q.pop_front();
                        chk(tb_if.err_code == exp_e, "err_code", tb_if.err_code, exp_e);
                    end
                end
                if (tb_if.frame_done) begin
                    chk(done_exp > 0, "done_expected", tb_if.frame_done, 0);
                    if (done_exp > 0) done_exp--;
                end
            end
            prev_en   = tb_if.wr_en && !rst;
            prev_ack  = tb_if.wr_ack;
            prev_addr = tb_if.wr_addr;
            prev_data = tb_if.wr_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got %0d checks", checks);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int n;
        tb_if.rx_dv   = 1'b0;
        tb_if.rx_byte = 8'h00;
        idle(3);
        chk(tb_if.wr_en == 1'b0,      "rst_wr_en",      tb_if.wr_en, 0);
        chk(tb_if.wr_addr == 8'h00,   "rst_wr_addr",    tb_if.wr_addr, 0);
        chk(tb_if.wr_data == 8'h00,   "rst_wr_data",    tb_if.wr_data, 0);
        chk(tb_if.frame_done == 1'b0, "rst_frame_done", tb_if.frame_done, 0);
        chk(tb_if.err == 1'b0,        "rst_err",        tb_if.err, 0);
        chk(tb_if.err_code == 2'd0,   "rst_err_code",   tb_if.err_code, 0);
        chk(tb_if.busy == 1'b0,       "rst_busy",       tb_if.busy, 0);
        rst = 1'b0;
        idle(2);

        // Non-sync bytes in IDLE are dropped silently
        txq = '{8'h00, 8'h12, 8'h10};
        send_txq();
        chk(tb_if.busy == 1'b0, "idle_garbage_busy", tb_if.busy, 0);

        // Good frame, with stray acks while wr_en is low
        stray_ack = 1'b1;
        wr_q.push_back(16'h10_11);
        wr_q.push_back(16'h11_22);
        done_exp++;
        txq = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
        send_txq();
        wait_quiet("quiet_good_frame");
        stray_ack = 1'b0;

        // Bad checksum: no writes, busy drops right after the CHK byte
        err_q.push_back(ERR_BAD_CHK);
        txq = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h00};
        send_txq();
        chk(tb_if.busy == 1'b0, "bad_chk_busy_low", tb_if.busy, 0);
        idle(2);

        // Bad length (too long, then zero), then a good frame
        err_q.push_back(ERR_BAD_LEN);
        txq = '{8'hA5, 8'h10, 8'h05};
        send_txq();
        err_q.push_back(ERR_BAD_LEN);
        txq = '{8'hA5, 8'h10, 8'h00};
        send_txq();
        wr_q.push_back(16'h20_7E);
        done_exp++;
        txq = '{8'hA5, 8'h20, 8'h01, 8'h7E, 8'h5F};
        send_txq();
        wait_quiet("quiet_after_bad_len");

        // Address wrap with delayed acks
        ack_delay = 3;
        wr_q.push_back(16'hFF_01);
        wr_q.push_back(16'h00_02);
        done_exp++;
        txq = '{8'hA5, 8'hFF, 8'h02, 8'h01, 8'h02, 8'hFE};
        send_txq();
        wait_quiet("quiet_wrap");

        // Full-length payload containing the sync value
        ack_delay = 1;
        wr_q.push_back(16'h30_A5);
        wr_q.push_back(16'h31_00);
        wr_q.push_back(16'h32_FF);
        wr_q.push_back(16'h33_5A);
        done_exp++;
        txq = '{8'hA5, 8'h30, 8'h04, 8'hA5, 8'h00, 8'hFF, 8'h5A, 8'h34};
        send_txq();
        wait_quiet("quiet_max_len");

        // Overrun during WRITE
        ack_delay = 2;
        wr_q.push_back(16'h40_99);
        err_q.push_back(ERR_OVERRUN);
        done_exp++;
        txq = '{8'hA5, 8'h40, 8'h01, 8'h99, 8'hD8, 8'h55};
        send_txq();
        wait_quiet("quiet_overrun_write");

        // Overruns in the last WRITE cycle and in DONE; done is deferred, not lost
        ack_delay = 0;
        wr_q.push_back(16'h50_66);
        err_q.push_back(ERR_OVERRUN);
        err_q.push_back(ERR_OVERRUN);
        done_exp++;
        txq = '{8'hA5, 8'h50, 8'h01, 8'h66, 8'h37, 8'h11, 8'h22};
        send_txq();
        wait_quiet("quiet_overrun_done");

        // Timeout while waiting for LEN, then while in DATA
        err_q.push_back(ERR_TIMEOUT);
        txq = '{8'hA5, 8'h10};
        send_txq();
        idle(TMO + 4);
        chk(tb_if.busy == 1'b0, "timeout_len_busy", tb_if.busy, 0);
        err_q.push_back(ERR_TIMEOUT);
        txq = '{8'hA5, 8'h10, 8'h02, 8'h11};
        send_txq();
        idle(TMO + 4);
        chk(tb_if.busy == 1'b0, "timeout_data_busy", tb_if.busy, 0);

        // Each byte arrives exactly on the last allowed cycle: no timeout
        wr_q.push_back(16'h60_77);
        done_exp++;
        send(8'hA5);
        txq = '{8'h60, 8'h01, 8'h77, 8'h16};
        foreach (txq[i]) begin
            idle(TMO - 1);
            send(txq[i]);
        end
        wait_quiet("quiet_timeout_edge");

        // Reset asserted mid-WRITE abandons the frame
        ack_delay = 5;
        txq = '{8'hA5, 8'h70, 8'h02, 8'h01, 8'h02, 8'h71};
        send_txq();
        n = 0;
        while (!tb_if.wr_en && n < 50) begin
            idle(1);
            n++;
        end
        chk(tb_if.wr_en == 1'b1, "mid_write_wr_en_seen", tb_if.wr_en, 1);
        idle(1);
        #2;
        rst = 1'b1;
        #1;
        chk(tb_if.wr_en == 1'b0,    "reset_wr_en_low", tb_if.wr_en, 0);
        chk(tb_if.busy == 1'b0,     "reset_busy_low",  tb_if.busy, 0);
        chk(tb_if.wr_addr == 8'h00, "reset_wr_addr",   tb_if.wr_addr, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(25);
        chk(tb_if.busy == 1'b0, "post_reset_idle", tb_if.busy, 0);

        chk(wr_q.size() == 0,  "writes_outstanding", wr_q.size(), 0);
        chk(err_q.size() == 0, "errs_outstanding",   err_q.size(), 0);
        chk(done_exp == 0,     "dones_outstanding",  done_exp, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
